fma_issue_arbiter: RTL and testbench

FMA_ISSUE_ARBITER -- requirements
Module: fma_issue_arbiter

---
 rtl/fma_arb_pkg.sv | 28 ++
 rtl/fma_arb_if.sv | 60 ++++++
 rtl/fma_issue_buf.sv | 65 ++++++
 rtl/fma_issue_arbiter.sv | 80 ++++++++
 tb/tb_fma_issue_arbiter.sv | 521 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fma_arb_pkg.sv
// fma_arb_pkg: shared robIdx type, flush
// predicates and constants for the FMA arbiter.
package fma_arb_pkg;
   localparam int PAYLOAD_W_DEF = 220;
   localparam logic [2:0] RM_DYN = 3'd7;

   typedef struct packed {
      logic       flag;
      logic [4:0] value;
   } rob_idx_t;

   function automatic logic isAfter(
      rob_idx_t a,
      rob_idx_t b
   );
      return (a.flag ^ b.flag) ^ (a.value > b.value);
   endfunction

   function automatic logic needFlush(
      rob_idx_t r,
      logic     rdValid,
      rob_idx_t rd,
      logic     rdLevel
   );
      return rdValid
         & (isAfter(r, rd) | (rdLevel & (r == rd)));
   endfunction
endpackage

// File: rtl/fma_arb_if.sv
// fma_arb_if: requester, redirect, issue and
// perf signals of the FMA issue arbiter.
interface fma_arb_if
   import fma_arb_pkg::*;
#(
   parameter int PAYLOAD_W = PAYLOAD_W_DEF
);
   logic [1:0]                req_valid;
   logic [1:0]                req_ready;
   logic [1:0]                req_robIdx_flag;
   logic [1:0][4:0]           req_robIdx_value;
   logic [1:0][2:0]           req_rm;
   logic [1:0][PAYLOAD_W-1:0] req_payload;
   logic [2:0]                frm;
   logic                      redirect_valid;
   logic                      redirect_robIdx_flag;
   logic [4:0]                redirect_robIdx_value;
   logic                      redirect_level;
   logic                      issue_valid;
   logic                      issue_ready;
   logic                      issue_robIdx_flag;
   logic [4:0]                issue_robIdx_value;
   logic [2:0]                issue_rm;
   logic                      issue_src;
   logic [PAYLOAD_W-1:0]      issue_payload;
   logic [15:0]               perf_issue_cnt;
   logic [15:0]               perf_conflict_cnt;

   modport master (
      output req_valid, req_robIdx_flag,
      output req_robIdx_value, req_rm,
      output req_payload, frm,
      output redirect_valid, redirect_level,
      output redirect_robIdx_flag,
      output redirect_robIdx_value,
      output issue_ready,
      input  req_ready, issue_valid,
      input  issue_robIdx_flag,
      input  issue_robIdx_value,
      input  issue_rm, issue_src,
      input  issue_payload,
      input  perf_issue_cnt, perf_conflict_cnt
   );

   modport slave (
      input  req_valid, req_robIdx_flag,
      input  req_robIdx_value, req_rm,
      input  req_payload, frm,
      input  redirect_valid, redirect_level,
      input  redirect_robIdx_flag,
      input  redirect_robIdx_value,
      input  issue_ready,
      output req_ready, issue_valid,
      output issue_robIdx_flag,
      output issue_robIdx_value,
      output issue_rm, issue_src,
      output issue_payload,
      output perf_issue_cnt, perf_conflict_cnt
   );
endinterface

// File: rtl/fma_issue_buf.sv
// fma_issue_buf: 2-entry in-order uop buffer
// with redirect flush and order-keeping compaction.
module fma_issue_buf
   import fma_arb_pkg::*;
#(
   parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enq,
   input  rob_idx_t             enqRob,
   input  logic [2:0]           enqRm,
   input  logic                 enqSrc,
   input  logic [PAYLOAD_W-1:0] enqPayload,
   input  logic                 deq,
   input  logic                 rdValid,
   input  rob_idx_t             rdRob,
   input  logic                 rdLevel,
   output logic [1:0]           count,
   output rob_idx_t             headRob,
   output logic [2:0]           headRm,
   output logic                 headSrc,
   output logic [PAYLOAD_W-1:0] headPayload
);
   typedef struct packed {
      rob_idx_t             rob;
      logic [2:0]           rm;
      logic                 src;
      logic [PAYLOAD_W-1:0] pl;
   } ent_t;

   ent_t slot0, slot1, inEnt;
   logic keep0, keep1, v0, v1;
   logic [1:0] countN;

   assign inEnt = {enqRob, enqRm, enqSrc, enqPayload};

   assign keep0 = (count != 2'd0)
      & ~needFlush(slot0.rob, rdValid, rdRob, rdLevel);
   assign keep1 = (count == 2'd2)
      & ~needFlush(slot1.rob, rdValid, rdRob, rdLevel);

   // a flushed head is already gone, so deq only pops a survivor
   assign v0 = keep0 & ~deq;
   assign v1 = keep1;
   assign countN = 2'(v0) + 2'(v1) + 2'(enq);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) count <= 2'd0;
      else        count <= countN;
   end

   always_ff @(posedge clock) begin
      if (!v0) begin
         if (v1)       slot0 <= slot1;
         else if (enq) slot0 <= inEnt;
      end
      if ((v0 ^ v1) & enq) slot1 <= inEnt;
   end

   assign headRob     = slot0.rob;
   assign headRm      = slot0.rm;
   assign headSrc     = slot0.src;
   assign headPayload = slot0.pl;
endmodule

// File: rtl/fma_issue_arbiter.sv
// fma_issue_arbiter: round-robin 2-port FMA
// issue arbiter with rm resolution and counters.
module fma_issue_arbiter
   import fma_arb_pkg::*;
#(
   parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
   input logic      clock,
   input logic      reset,
   fma_arb_if.slave bus
);
   rob_idx_t [1:0] reqRob;
   rob_idx_t redir, headRob;
   logic [1:0] grant, count;
   logic full, acc, sel, enqStore, deq, rrPtr;
   logic [2:0] enqRm;
   logic [15:0] issueCnt, conflictCnt;

   assign reqRob[0] = {bus.req_robIdx_flag[0],
                       bus.req_robIdx_value[0]};
   assign reqRob[1] = {bus.req_robIdx_flag[1],
                       bus.req_robIdx_value[1]};
   assign redir = {bus.redirect_robIdx_flag,
                   bus.redirect_robIdx_value};

   assign grant[0] = bus.req_valid[0]
      & (~bus.req_valid[1] | ~rrPtr);
   assign grant[1] = bus.req_valid[1]
      & (~bus.req_valid[0] | rrPtr);

   assign full = count == 2'd2;
   assign bus.req_ready = grant & {2{~full & reset}};
   assign acc = |bus.req_ready;
   assign sel = bus.req_ready[1];

   assign enqRm = (bus.req_rm[sel] == RM_DYN)
      ? bus.frm : bus.req_rm[sel];
   // flushed requests are acknowledged but dropped
   assign enqStore = acc & ~needFlush(reqRob[sel],
      bus.redirect_valid, redir, bus.redirect_level);
   assign deq = bus.issue_valid & bus.issue_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rrPtr       <= 1'b0;
         issueCnt    <= 16'd0;
         conflictCnt <= 16'd0;
      end else begin
         if (acc) rrPtr <= ~sel;
         if (deq) issueCnt <= issueCnt + 16'd1;
         if (&bus.req_valid)
            conflictCnt <= conflictCnt + 16'd1;
      end
   end

   fma_issue_buf #(.PAYLOAD_W(PAYLOAD_W)) uBuf (
      .clock       (clock),
      .reset       (reset),
      .enq         (enqStore),
      .enqRob      (reqRob[sel]),
      .enqRm       (enqRm),
      .enqSrc      (sel),
      .enqPayload  (bus.req_payload[sel]),
      .deq         (deq),
      .rdValid     (bus.redirect_valid),
      .rdRob       (redir),
      .rdLevel     (bus.redirect_level),
      .count       (count),
      .headRob     (headRob),
      .headRm      (bus.issue_rm),
      .headSrc     (bus.issue_src),
      .headPayload (bus.issue_payload)
   );

   assign bus.issue_valid        = count != 2'd0;
   assign bus.issue_robIdx_flag  = headRob.flag;
   assign bus.issue_robIdx_value = headRob.value;
   assign bus.perf_issue_cnt     = issueCnt;
   assign bus.perf_conflict_cnt  = conflictCnt;
endmodule

// File: tb/tb_fma_issue_arbiter.sv
// tb_fma_issue_arbiter: directed scenarios plus
// randomized run against a queue-based model.
module tb_fma_issue_arbiter;
   localparam int PW = 48;

   logic clock;
   logic reset;
   int nCmp = 0;
   int nErr = 0;

   fma_arb_if #(.PAYLOAD_W(PW)) bus();

   fma_issue_arbiter #(.PAYLOAD_W(PW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      bit          f;
      bit [4:0]    v;
      bit [2:0]    rm;
      bit          src;
      logic [PW-1:0] pl;
   } ment_t;

   ment_t mq[$];

   task automatic idle();
      bus.req_valid = 2'b00;
      bus.req_robIdx_flag = 2'b00;
      bus.req_robIdx_value = '0;
      bus.req_rm = '0;
      bus.req_payload = '0;
      bus.frm = 3'd0;
      bus.redirect_valid = 1'b0;
      bus.redirect_robIdx_flag = 1'b0;
      bus.redirect_robIdx_value = 5'd0;
      bus.redirect_level = 1'b0;
      bus.issue_ready = 1'b0;
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle();
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic setPort(input int p, input bit f,
      input bit [4:0] v, input bit [2:0] rm,
      input logic [PW-1:0] pl);
      bus.req_valid[p] = 1'b1;
      bus.req_robIdx_flag[p] = f;
      bus.req_robIdx_value[p] = v;
      bus.req_rm[p] = rm;
      bus.req_payload[p] = pl;
   endtask

   task automatic setRedir(input bit en, input bit f,
      input bit [4:0] v, input bit lvl);
      bus.redirect_valid = en;
      bus.redirect_robIdx_flag = f;
      bus.redirect_robIdx_value = v;
      bus.redirect_level = lvl;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle();
      bus.req_valid = 2'b11;
      bus.issue_ready = 1'b1;
      tick();
      tick();
      #1;
      nCmp++;
      if (bus.req_ready !== 2'b00) begin
         nErr++;
         $display("FAIL rst_ready got=%b exp=00",
            bus.req_ready);
      end
      nCmp++;
      if (bus.issue_valid !== 1'b0) begin
         nErr++;
         $display("FAIL rst_valid got=%b exp=0",
            bus.issue_valid);
      end
      nCmp++;
      if (bus.perf_issue_cnt !== 16'd0 ||
          bus.perf_conflict_cnt !== 16'd0) begin
         nErr++;
         $display("FAIL rst_cnt got=%0d/%0d exp=0/0",
            bus.perf_issue_cnt, bus.perf_conflict_cnt);
      end
   endtask

   task automatic test_alternate();
      do_reset();
      setPort(0, 0, 5'd1, 3'd0, 48'h111);
      setPort(1, 0, 5'd2, 3'd0, 48'h222);
      bus.issue_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         nCmp++;
         if (bus.req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
            nErr++;
            $display("FAIL alt_ready k=%0d got=%b", k,
               bus.req_ready);
         end
         if (k > 0) begin
            nCmp++;
            if (bus.issue_valid !== 1'b1 ||
                bus.issue_src !== 1'((k - 1) % 2)) begin
               nErr++;
               $display("FAIL alt_src k=%0d got=%b/%b exp=1/%0d",
                  k, bus.issue_valid, bus.issue_src, (k - 1) % 2);
            end
         end
         nCmp++;
         if (bus.perf_conflict_cnt !== 16'(k)) begin
            nErr++;
            $display("FAIL alt_conflict k=%0d got=%0d exp=%0d",
               k, bus.perf_conflict_cnt, k);
         end
         tick();
      end
      idle();
   endtask

   task automatic test_backpressure();
      do_reset();
      setPort(0, 0, 5'd1, 3'd0, 48'h1);
      #1;
      nCmp++;
      if (bus.req_ready !== 2'b01) begin
         nErr++;
         $display("FAIL bp_acc1 got=%b exp=01", bus.req_ready);
      end
      tick();
      setPort(0, 0, 5'd2, 3'd0, 48'h2);
      #1;
      nCmp++;
      if (bus.req_ready !== 2'b01) begin
         nErr++;
         $display("FAIL bp_acc2 got=%b exp=01", bus.req_ready);
      end
      tick();
      setPort(0, 0, 5'd3, 3'd0, 48'h3);
      #1;
      nCmp++;
      if (bus.req_ready !== 2'b00 || bus.issue_valid !== 1'b1 ||
          bus.issue_robIdx_value !== 5'd1) begin
         nErr++;
         $display("FAIL bp_full got=%b/%b/%0d exp=00/1/1",
            bus.req_ready, bus.issue_valid,
            bus.issue_robIdx_value);
      end
      tick();
      bus.issue_ready = 1'b1;
      #1;
      nCmp++;
      if (bus.req_ready !== 2'b00) begin
         nErr++;
         $display("FAIL bp_noready got=%b exp=00", bus.req_ready);
      end
      tick();
      #1;
      nCmp++;
      if (bus.req_ready !== 2'b01 ||
          bus.issue_robIdx_value !== 5'd2) begin
         nErr++;
         $display("FAIL bp_order2 got=%b/%0d exp=01/2",
            bus.req_ready, bus.issue_robIdx_value);
      end
      tick();
      bus.req_valid = 2'b00;
      #1;
      nCmp++;
      if (bus.issue_valid !== 1'b1 ||
          bus.issue_robIdx_value !== 5'd3 ||
          bus.issue_payload !== 48'h3) begin
         nErr++;
         $display("FAIL bp_order3 got=%b/%0d exp=1/3",
            bus.issue_valid, bus.issue_robIdx_value);
      end
      tick();
      #1;
      nCmp++;
      if (bus.issue_valid !== 1'b0 ||
          bus.perf_issue_cnt !== 16'd3) begin
         nErr++;
         $display("FAIL bp_drain got=%b/%0d exp=0/3",
            bus.issue_valid, bus.perf_issue_cnt);
      end
      idle();
   endtask

   task automatic test_rm();
      do_reset();
      bus.frm = 3'd3;
      setPort(0, 0, 5'd1, 3'd7, 48'h0);
      tick();
      bus.req_valid = 2'b00;
      bus.frm = 3'd5;
      #1;
      nCmp++;
      if (bus.issue_rm !== 3'd3) begin
         nErr++;
         $display("FAIL rm_dyn got=%0d exp=3", bus.issue_rm);
      end
      bus.issue_ready = 1'b1;
      bus.frm = 3'd3;
      setPort(0, 0, 5'd2, 3'd1, 48'h0);
      tick();
      bus.req_valid = 2'b00;
      #1;
      nCmp++;
      if (bus.issue_valid !== 1'b1 ||
          bus.issue_robIdx_value !== 5'd2 ||
          bus.issue_rm !== 3'd1) begin
         nErr++;
         $display("FAIL rm_static got=%b/%0d/%0d exp=1/2/1",
            bus.issue_valid, bus.issue_robIdx_value,
            bus.issue_rm);
      end
      tick();
      idle();
   endtask

   task automatic test_flush();
      logic [15:0] ic;
      do_reset();
      setPort(0, 0, 5'd4, 3'd0, 48'h4);
      tick();
      setPort(0, 0, 5'd9, 3'd0, 48'h9);
      tick();
      bus.req_valid = 2'b00;
      setRedir(1, 0, 5'd6, 0);
      tick();
      setRedir(0, 0, 5'd0, 0);
      setPort(0, 0, 5'd12, 3'd0, 48'h0);
      #1;
      nCmp++;
      if (bus.req_ready !== 2'b01 ||
          bus.issue_robIdx_value !== 5'd4) begin
         nErr++;
         $display("FAIL fl_tail got=%b/%0d exp=01/4",
            bus.req_ready, bus.issue_robIdx_value);
      end
      bus.req_valid = 2'b00;
      setRedir(1, 0, 5'd4, 0);
      tick();
      setRedir(0, 0, 5'd0, 0);
      #1;
      nCmp++;
      if (bus.issue_valid !== 1'b1 ||
          bus.issue_robIdx_value !== 5'd4) begin
         nErr++;
         $display("FAIL fl_lvl0 got=%b/%0d exp=1/4",
            bus.issue_valid, bus.issue_robIdx_value);
      end
      setRedir(1, 0, 5'd4, 1);
      tick();
      setRedir(0, 0, 5'd0, 0);
      #1;
      nCmp++;
      if (bus.issue_valid !== 1'b0) begin
         nErr++;
         $display("FAIL fl_lvl1 got=%b exp=0", bus.issue_valid);
      end
      setRedir(1, 0, 5'd6, 0);
      setPort(0, 0, 5'd20, 3'd0, 48'h0);
      #1;
      nCmp++;
      if (bus.req_ready !== 2'b01) begin
         nErr++;
         $display("FAIL fl_in_ack got=%b exp=01", bus.req_ready);
      end
      tick();
      setRedir(0, 0, 5'd0, 0);
      bus.req_valid = 2'b00;
      #1;
      nCmp++;
      if (bus.issue_valid !== 1'b0) begin
         nErr++;
         $display("FAIL fl_in_drop got=%b exp=0",
            bus.issue_valid);
      end
      setPort(0, 0, 5'd10, 3'd0, 48'h0);
      tick();
      bus.req_valid = 2'b00;
      bus.issue_ready = 1'b1;
      setRedir(1, 0, 5'd6, 0);
      #1;
      ic = bus.perf_issue_cnt;
      nCmp++;
      if (bus.issue_valid !== 1'b1 ||
          bus.issue_robIdx_value !== 5'd10) begin
         nErr++;
         $display("FAIL fl_handover got=%b/%0d exp=1/10",
            bus.issue_valid, bus.issue_robIdx_value);
      end
      tick();
      setRedir(0, 0, 5'd0, 0);
      #1;
      nCmp++;
      if (bus.issue_valid !== 1'b0 ||
          bus.perf_issue_cnt !== ic + 16'd1) begin
         nErr++;
         $display("FAIL fl_handover_deq got=%b/%0d exp=0/%0d",
            bus.issue_valid, bus.perf_issue_cnt, ic + 16'd1);
      end
      idle();
   endtask

   task automatic test_flag_wrap();
      do_reset();
      setPort(0, 0, 5'd29, 3'd0, 48'h0);
      tick();
      setPort(0, 1, 5'd2, 3'd0, 48'h0);
      tick();
      bus.req_valid = 2'b00;
      setRedir(1, 0, 5'd30, 0);
      tick();
      setRedir(0, 0, 5'd0, 0);
      setPort(0, 0, 5'd1, 3'd0, 48'h0);
      #1;
      nCmp++;
      if (bus.req_ready !== 2'b01 ||
          bus.issue_robIdx_flag !== 1'b0 ||
          bus.issue_robIdx_value !== 5'd29) begin
         nErr++;
         $display("FAIL wrap_keep got=%b/%b/%0d exp=01/0/29",
            bus.req_ready, bus.issue_robIdx_flag,
            bus.issue_robIdx_value);
      end
      bus.req_valid = 2'b00;
      bus.issue_ready = 1'b1;
      tick();
      #1;
      nCmp++;
      if (bus.issue_valid !== 1'b0) begin
         nErr++;
         $display("FAIL wrap_flushed got=%b exp=0",
            bus.issue_valid);
      end
      idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      setPort(0, 0, 5'd1, 3'd0, 48'h0);
      setPort(1, 0, 5'd2, 3'd0, 48'h0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      nCmp++;
      if (bus.issue_valid !== 1'b0 ||
          bus.req_ready !== 2'b00) begin
         nErr++;
         $display("FAIL rmid_out got=%b/%b exp=0/00",
            bus.issue_valid, bus.req_ready);
      end
      nCmp++;
      if (bus.perf_issue_cnt !== 16'd0 ||
          bus.perf_conflict_cnt !== 16'd0) begin
         nErr++;
         $display("FAIL rmid_cnt got=%0d/%0d exp=0/0",
            bus.perf_issue_cnt, bus.perf_conflict_cnt);
      end
      tick();
      reset = 1'b1;
      bus.req_valid = 2'b00;
      setPort(0, 0, 5'd17, 3'd0, 48'h0);
      #1;
      nCmp++;
      if (bus.req_ready !== 2'b01) begin
         nErr++;
         $display("FAIL rmid_acc got=%b exp=01", bus.req_ready);
      end
      tick();
      bus.req_valid = 2'b00;
      #1;
      nCmp++;
      if (bus.issue_valid !== 1'b1 ||
          bus.issue_robIdx_value !== 5'd17) begin
         nErr++;
         $display("FAIL rmid_first got=%b/%0d exp=1/17",
            bus.issue_valid, bus.issue_robIdx_value);
      end
      idle();
   endtask

   function automatic bit younger(bit f, bit [4:0] v,
      bit rf, bit [4:0] rv);
      if (f == rf) return v > rv;
      return v <= rv;
   endfunction

   function automatic bit mFlush(bit f, bit [4:0] v);
      if (!bus.redirect_valid) return 0;
      if (younger(f, v, bus.redirect_robIdx_flag,
                  bus.redirect_robIdx_value)) return 1;
      return bus.redirect_level &&
         f == bus.redirect_robIdx_flag &&
         v == bus.redirect_robIdx_value;
   endfunction

   task automatic test_random();
      int rr, mIss, mCon, p;
      bit [1:0] expR;
      bit headGone, doDeq;
      logic [63:0] r64;
      ment_t e, sv[$];
      do_reset();
      mq.delete();
      rr = 0;
      mIss = 0;
      mCon = 0;
      for (int c = 0; c < 600; c++) begin
         bus.req_valid = 2'($urandom);
         for (int i = 0; i < 2; i++) begin
            bus.req_robIdx_flag[i] = 1'($urandom);
            bus.req_robIdx_value[i] = 5'($urandom);
            bus.req_rm[i] = 3'($urandom);
            r64 = {$urandom, $urandom};
            bus.req_payload[i] = r64[PW-1:0];
         end
         bus.frm = 3'($urandom);
         bus.redirect_valid = ($urandom_range(0, 9) < 2);
         bus.redirect_robIdx_flag = 1'($urandom);
         bus.redirect_robIdx_value = 5'($urandom);
         bus.redirect_level = 1'($urandom);
         bus.issue_ready = ($urandom_range(0, 9) < 7);
         #1;
         if (mq.size() == 2) expR = 2'b00;
         else if (bus.req_valid == 2'b11)
            expR = (rr == 0) ? 2'b01 : 2'b10;
         else expR = bus.req_valid;
         nCmp++;
         if (bus.req_ready !== expR ||
             bus.issue_valid !== (mq.size() > 0)) begin
            nErr++;
            $display("FAIL rnd_hs c=%0d got=%b/%b exp=%b/%b",
               c, bus.req_ready, bus.issue_valid,
               expR, mq.size() > 0);
         end
         if (mq.size() > 0) begin
            e = mq[0];
            nCmp++;
            if ({bus.issue_robIdx_flag, bus.issue_robIdx_value,
                 bus.issue_rm, bus.issue_src,
                 bus.issue_payload} !==
                {e.f, e.v, e.rm, e.src, e.pl}) begin
               nErr++;
               $display("FAIL rnd_head c=%0d got=%b/%0d/%0d/%b/%h exp=%b/%0d/%0d/%b/%h",
                  c, bus.issue_robIdx_flag,
                  bus.issue_robIdx_value, bus.issue_rm,
                  bus.issue_src, bus.issue_payload,
                  e.f, e.v, e.rm, e.src, e.pl);
            end
         end
         nCmp++;
         if (bus.perf_issue_cnt !== 16'(mIss) ||
             bus.perf_conflict_cnt !== 16'(mCon)) begin
            nErr++;
            $display("FAIL rnd_cnt c=%0d got=%0d/%0d exp=%0d/%0d",
               c, bus.perf_issue_cnt, bus.perf_conflict_cnt,
               16'(mIss), 16'(mCon));
         end
         doDeq = (mq.size() > 0) && bus.issue_ready;
         headGone = (mq.size() > 0) && mFlush(mq[0].f, mq[0].v);
         sv.delete();
         foreach (mq[i])
            if (!mFlush(mq[i].f, mq[i].v)) sv.push_back(mq[i]);
         mq = sv;
         if (doDeq && !headGone) void'(mq.pop_front());
         if (expR != 2'b00) begin
            p = expR[1] ? 1 : 0;
            e.f = bus.req_robIdx_flag[p];
            e.v = bus.req_robIdx_value[p];
            e.rm = (bus.req_rm[p] == 3'd7) ? bus.frm
                                            : bus.req_rm[p];
            e.src = 1'(p);
            e.pl = bus.req_payload[p];
            if (!mFlush(e.f, e.v)) mq.push_back(e);
            rr = 1 - p;
         end
         if (doDeq) mIss++;
         if (bus.req_valid == 2'b11) mCon++;
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      reset = 1'b0;
      test_reset();
      test_alternate();
      test_backpressure();
      test_rm();
      test_flush();
      test_flag_wrap();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
         nCmp, nErr);
      $finish;
   end
endmodule
